// File: rtl/riscv_muldiv_wb_tracker.sv
// In-order tag tracker that turns untagged mul/div responses into registered writebacks.
// Optional macro RISCV_MULDIV_DIV0_FIXUP_EN: store divide-by-zero info per tag and patch DIV/REM results.
module riscv_muldiv_wb_tracker #(
    parameter int DEPTH = 4,
    parameter int PTRW  = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        issue_go,
    input  logic [2:0]  issue_fn,
    input  logic [4:0]  issue_waddr,
    input  logic [31:0] issue_a,
    input  logic [31:0] issue_b,
    output logic        issue_rdy,
    input  logic        resp_val,
    input  logic [63:0] resp_result,
    output logic        resp_rdy,
    output logic        wb_val,
    output logic [4:0]  wb_waddr,
    output logic [31:0] wb_data,
    input  logic        wb_rdy
);

    typedef enum logic [2:0] {
        FN_MUL  = 3'd0,
        FN_DIV  = 3'd1,
        FN_DIVU = 3'd2,
        FN_REM  = 3'd3,
        FN_REMU = 3'd4
    } fn_e;

    localparam logic [PTRW:0] CountFull = (PTRW+1)'(DEPTH);

    logic [2:0]      fn_q    [DEPTH];
    logic [4:0]      waddr_q [DEPTH];
    logic [PTRW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTRW-1:0] rd_ptr_q, rd_ptr_d;
    logic [PTRW:0]   count_q, count_d;
    logic            wb_val_q, wb_val_d;
    logic [4:0]      wb_waddr_q, wb_waddr_d;
    logic [31:0]     wb_data_q, wb_data_d;

    logic            full;
    logic            empty;
    logic            resp_fire;
    logic            push;
    logic [2:0]      head_fn;
    logic [31:0]     sel;

`ifdef RISCV_MULDIV_DIV0_FIXUP_EN
    logic            bzero_q [DEPTH];
    logic [31:0]     a_q     [DEPTH];
`else
    logic            unused_operands;
    assign unused_operands = ^{issue_a, issue_b};
`endif

    assign full      = (count_q == CountFull);
    assign empty     = (count_q == '0);
    assign issue_rdy = !full;
    assign resp_rdy  = (!wb_val_q || wb_rdy) && !empty;
    assign resp_fire = resp_val && resp_rdy;
    // A push into a full FIFO is only safe when the head leaves in the same cycle.
    assign push      = issue_go && (!full || resp_fire);

    assign wb_val    = wb_val_q;
    assign wb_waddr  = wb_waddr_q;
    assign wb_data   = wb_data_q;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
        end
        if (resp_fire) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        count_d = count_q + (PTRW+1)'(push) - (PTRW+1)'(resp_fire);
    end

    always_comb begin
        head_fn = fn_q[rd_ptr_q];
        case (head_fn)
            FN_MUL, FN_DIV, FN_DIVU: sel = resp_result[31:0];
            FN_REM, FN_REMU:         sel = resp_result[63:32];
            default:                 sel = 'x;
        endcase
`ifdef RISCV_MULDIV_DIV0_FIXUP_EN
        if (bzero_q[rd_ptr_q]) begin
            case (head_fn)
                FN_DIV, FN_DIVU: sel = 32'hffff_ffff;
                FN_REM, FN_REMU: sel = a_q[rd_ptr_q];
                default:         sel = sel;
            endcase
        end
`endif
    end

    always_comb begin
        wb_val_d   = wb_val_q;
        wb_waddr_d = wb_waddr_q;
        wb_data_d  = wb_data_q;
        if (resp_fire) begin
            wb_val_d   = 1'b1;
            wb_waddr_d = waddr_q[rd_ptr_q];
            wb_data_d  = sel;
        end else if (wb_rdy) begin
            wb_val_d   = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            wb_val_q   <= 1'b0;
            wb_waddr_q <= '0;
            wb_data_q  <= '0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            wb_val_q   <= wb_val_d;
            wb_waddr_q <= wb_waddr_d;
            wb_data_q  <= wb_data_d;
        end
    end

    // Tag payload needs no reset; it is only read behind a valid count.
    always_ff @(posedge clk) begin
        if (!reset && push) begin
            fn_q[wr_ptr_q]    <= issue_fn;
            waddr_q[wr_ptr_q] <= issue_waddr;
`ifdef RISCV_MULDIV_DIV0_FIXUP_EN
            bzero_q[wr_ptr_q] <= (issue_b == 32'd0);
            a_q[wr_ptr_q]     <= issue_a;
`endif
        end
    end

`ifndef SYNTHESIS
    always_ff @(posedge clk) begin
        if (!reset) begin
            assert (!(issue_go && full && !resp_fire))
                else $error("riscv_muldiv_wb_tracker: issue_go while tag FIFO full");
            assert (!(resp_val && empty))
                else $error("riscv_muldiv_wb_tracker: resp_val with no pending tag");
        end
    end
`endif

endmodule

// File: tb/tb_riscv_muldiv_wb_tracker.sv
// Scoreboard bench for riscv_muldiv_wb_tracker: a behavioural mul/div unit feeds responses,
// a decoupled monitor checks every writeback in order.
module tb_riscv_muldiv_wb_tracker;

    localparam int DEPTH = 4;
    localparam logic [2:0] MUL = 3'd0, DIV = 3'd1, DIVU = 3'd2, REM = 3'd3, REMU = 3'd4;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        issue_go = 1'b0;
    logic [2:0]  issue_fn = '0;
    logic [4:0]  issue_waddr = '0;
    logic [31:0] issue_a = '0;
    logic [31:0] issue_b = '0;
    logic        issue_rdy;
    logic        resp_val = 1'b0;
    logic [63:0] resp_result = '0;
    logic        resp_rdy;
    logic        wb_val;
    logic [4:0]  wb_waddr;
    logic [31:0] wb_data;
    logic        wb_rdy = 1'b1;

    int testsRun = 0;
    int testsFailed = 0;

    logic [63:0] pendQ[$];
    logic [36:0] expQ[$];
    int          mCount = 0;
    bit          mWbVal = 1'b0;

    riscv_muldiv_wb_tracker #(.DEPTH(DEPTH), .PTRW(2)) dut (
        .clk(clk), .reset(reset),
        .issue_go(issue_go), .issue_fn(issue_fn), .issue_waddr(issue_waddr),
        .issue_a(issue_a), .issue_b(issue_b), .issue_rdy(issue_rdy),
        .resp_val(resp_val), .resp_result(resp_result), .resp_rdy(resp_rdy),
        .wb_val(wb_val), .wb_waddr(wb_waddr), .wb_data(wb_data), .wb_rdy(wb_rdy)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
        testsRun++;
        if (actual !== expected) begin
            testsFailed++;
            $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, actual, expected, $time);
        end
    endtask

    // Behavioural mul/div unit: full product, or {remainder, quotient}; divide by zero yields junk.
    function automatic logic [63:0] muldivModel(input logic [2:0] fn, input logic [31:0] a, input logic [31:0] b);
        longint sa, sb, q, r;
        longint unsigned ua, ub;
        ua = {32'd0, a};
        ub = {32'd0, b};
        if (fn == MUL) return ua * ub;
        if (b == 32'd0) return {$urandom, $urandom};
        if (fn == DIV || fn == REM) begin
            sa = longint'(signed'(a));
            sb = longint'(signed'(b));
            q = sa / sb;
            r = sa % sb;
            return {r[31:0], q[31:0]};
        end
        return {32'(ua % ub), 32'(ua / ub)};
    endfunction

    function automatic logic [31:0] expectedWb(input logic [2:0] fn, input logic [31:0] a,
                                               input logic [31:0] b, input logic [63:0] res);
`ifdef RISCV_MULDIV_DIV0_FIXUP_EN
        if (b == 32'd0 && (fn == DIV || fn == DIVU)) return 32'hffff_ffff;
        if (b == 32'd0 && (fn == REM || fn == REMU)) return a;
`endif
        if (fn == REM || fn == REMU) return res[63:32];
        return res[31:0];
    endfunction

    // One clock cycle of stimulus; entered and left 1 time unit after a rising edge.
    task automatic applyStimulus(input bit doIssue, input logic [2:0] fn, input logic [4:0] waddr,
                                 input logic [31:0] a, input logic [31:0] b,
                                 input bit doResp, input bit wbRdy);
        bit fire, push, expRespRdy;
        logic [63:0] res;
        wb_rdy = wbRdy;
        resp_val = doResp && (pendQ.size() > 0);
        resp_result = resp_val ? pendQ[0] : {$urandom, $urandom};
        #1;
        expRespRdy = (!mWbVal || wbRdy) && (mCount != 0);
        checkOutput("issue_rdy", issue_rdy, (mCount != DEPTH));
        checkOutput("resp_rdy", resp_rdy, expRespRdy);
        fire = resp_val && expRespRdy;
        push = doIssue && ((mCount != DEPTH) || fire);
        issue_go = push;
        issue_fn = fn;
        issue_waddr = waddr;
        issue_a = a;
        issue_b = b;
        if (push) begin
            res = muldivModel(fn, a, b);
            pendQ.push_back(res);
            expQ.push_back({waddr, expectedWb(fn, a, b, res)});
        end
        @(posedge clk);
        mCount = mCount + int'(push) - int'(fire);
        if (fire) void'(pendQ.pop_front());
        mWbVal = fire ? 1'b1 : (wbRdy ? 1'b0 : mWbVal);
        #1;
        issue_go = 1'b0;
        resp_val = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) applyStimulus(0, MUL, 5'd0, 32'd0, 32'd0, 0, 1);
    endtask

    task automatic respond(input int n, input bit wbRdy);
        for (int i = 0; i < n; i++) applyStimulus(0, MUL, 5'd0, 32'd0, 32'd0, 1, wbRdy);
    endtask

    task automatic randomCycles(input int n);
        logic [31:0] b;
        for (int i = 0; i < n; i++) begin
            b = ($urandom_range(0, 5) == 0) ? 32'd0 : (($urandom_range(0, 1) == 1) ? $urandom : 32'($urandom_range(1, 20)));
            applyStimulus($urandom_range(0, 99) < 60, 3'($urandom_range(0, 4)), 5'($urandom),
                          $urandom, b, $urandom_range(0, 99) < 55, $urandom_range(0, 99) < 75);
        end
    endtask

    task automatic doReset();
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        mCount = 0;
        mWbVal = 1'b0;
        pendQ.delete();
        expQ.delete();
        #1;
        checkOutput("rst_wb_val", wb_val, 1'b0);
        checkOutput("rst_wb_waddr", wb_waddr, 5'd0);
        checkOutput("rst_wb_data", wb_data, 32'd0);
        checkOutput("rst_issue_rdy", issue_rdy, 1'b1);
        checkOutput("rst_resp_rdy", resp_rdy, 1'b0);
    endtask

    // Monitor: every presented writeback must match the oldest expected entry, held until taken.
    always @(negedge clk) begin
        if (!reset) begin
            checkOutput("wb_val", wb_val, mWbVal);
            if (wb_val === 1'b1) begin
                if (expQ.size() == 0) begin
                    testsRun++;
                    testsFailed++;
                    $display("[TB] FAIL wb_unexpected: got waddr %0d data %0h expected no writeback", wb_waddr, wb_data);
                end else begin
                    checkOutput("wb_waddr", wb_waddr, expQ[0][36:32]);
                    checkOutput("wb_data", wb_data, expQ[0][31:0]);
                    if (wb_rdy) void'(expQ.pop_front());
                end
            end
        end
    end

    initial begin
        #300000;
        $display("[TB] FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int guard;
        repeat (2) @(posedge clk);
        #1;
        doReset();
        idle(2);

        applyStimulus(1, MUL, 5'd5, 32'd7, 32'd6, 0, 1);
        respond(1, 1);
        idle(2);

        applyStimulus(1, REM, 5'd3, 32'd10, 32'd3, 0, 1);
        applyStimulus(1, DIVU, 5'd4, 32'd83, 32'd9, 0, 1);
        respond(2, 1);
        idle(2);

        for (int i = 0; i < 4; i++) applyStimulus(1, 3'(i % 5), 5'(10 + i), 32'(100 + i), 32'(3 + i), 0, 1);
        applyStimulus(1, REMU, 5'd20, 32'd50, 32'd7, 1, 1);
        applyStimulus(1, DIV, 5'd21, 32'hffff_fff0, 32'd3, 1, 1);
        respond(6, 1);
        idle(1);

        applyStimulus(1, MUL, 5'd11, 32'd3, 32'd3, 0, 1);
        applyStimulus(1, DIVU, 5'd12, 32'd99, 32'd4, 0, 1);
        respond(1, 0);
        respond(3, 0);
        respond(3, 1);
        idle(1);

        applyStimulus(1, DIV, 5'd7, 32'd5, 32'd0, 0, 1);
        applyStimulus(1, REM, 5'd8, 32'd5, 32'd0, 0, 1);
        respond(2, 1);
        idle(2);

        randomCycles(600);

        applyStimulus(1, MUL, 5'd1, 32'd2, 32'd2, 0, 0);
        applyStimulus(1, DIV, 5'd2, 32'd9, 32'd2, 0, 0);
        respond(1, 0);
        applyStimulus(1, REM, 5'd3, 32'd9, 32'd2, 0, 0);
        doReset();
        idle(2);

        randomCycles(200);

        guard = 0;
        while ((pendQ.size() > 0 || mWbVal) && guard < 200) begin
            respond(1, 1);
            guard++;
        end
        idle(2);
        checkOutput("drain_pending", 64'(pendQ.size()), 64'd0);
        checkOutput("drain_expected", 64'(expQ.size()), 64'd0);

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
